gpio_serial_loader: RTL and testbench

- Transmitter end of the user-area GPIO configuration chain.
- Walks a per-pad configuration store and shifts each pad's word, bit-serially, into the daisy-chained per-pad control blocks, using generated serial_clock and serial_data.
- Pulses serial_load when the shift is complete, so every pad latches its new mode together: DM, INP_DIS, VTRIP_SEL, SLOW, HLD_OVR, analog controls and OE override.
- Lives in housekeeping and is triggered by a register write.

---
 rtl/gpio_serial_loader.sv | 182 ++++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: transmitter end of the user-area GPIO configuration
// chain. On start it walks the per-pad configuration store from pad NPADS-1
// down to pad 0, shifting each word MSB first into the daisy-chained pad
// control blocks on serial_clock/serial_data. It then pulses serial_load so
// every pad latches its new mode in the same cycle.
//
// Optional feature, enabled by defining GPIO_LOADER_READBACK_EN:
//   adds serial_return (tail of the chain) and rb_word. rb_word is the last
//   CFG_BITS bits shifted out of the chain, which is the previous config of
//   pad 0.
//
// Handshake: start is a one-cycle request. It is accepted only in IDLE, which
// includes the cycle where done is high. A start seen while a load is in
// progress is dropped and never queued. busy is high from the cycle after
// acceptance until done. done is a one-cycle pulse. cfg_data must be valid
// one cycle after cfg_idx changes.
//
// The FSM state is held in the 'state' register for checkers to observe.
module gpio_serial_loader #(
  parameter int NPADS    = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 4
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       start,
  output logic [$clog2(NPADS)-1:0]   cfg_idx,
  input  logic [CFG_BITS-1:0]        cfg_data,
  output logic                       serial_clock,
  output logic                       serial_data,
  output logic                       serial_load,
  output logic                       busy,
`ifdef GPIO_LOADER_READBACK_EN
  input  logic                       serial_return,
  output logic [CFG_BITS-1:0]        rb_word,
`endif
  output logic                       done
);

  localparam int IW = $clog2(NPADS);
  localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [IW-1:0] IDX_LAST   = IW'(NPADS - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CFG_BITS - 1);
  localparam logic [7:0]    PHASE_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOW,
    S_HIGH,
    S_LOAD,
    S_FIN
  } state_t;

  state_t              state;
  logic [7:0]          phase_cnt;
  logic                fetch_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [CFG_BITS-1:0] shreg;
`ifdef GPIO_LOADER_READBACK_EN
  logic [CFG_BITS-1:0] rb_shift;
`endif

  logic phase_end;

  // Last cycle of a LOW, HIGH or LOAD phase.
  assign phase_end = (phase_cnt == PHASE_LAST);

  // Sequencer: fetch a word, shift it out bit by bit, then latch the chain.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= S_IDLE;
      phase_cnt    <= 8'd0;
      fetch_cnt    <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cfg_idx      <= IDX_LAST;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef GPIO_LOADER_READBACK_EN
      rb_shift     <= '0;
      rb_word      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_FETCH;
            busy      <= 1'b1;
            cfg_idx   <= IDX_LAST;
            fetch_cnt <= 1'b0;
          end
        end

        // First cycle lets cfg_idx settle at the store; the second latches
        // the word the store returns.
        S_FETCH: begin
          if (!fetch_cnt) begin
            fetch_cnt <= 1'b1;
          end else begin
            fetch_cnt    <= 1'b0;
            shreg        <= cfg_data;
            bit_cnt      <= BIT_LAST;
            phase_cnt    <= 8'd0;
            serial_clock <= 1'b0;
            serial_data  <= cfg_data[CFG_BITS-1];
            state        <= S_LOW;
          end
        end

        // Data was set up at LOW entry; raise the clock once the phase ends.
        S_LOW: begin
          if (phase_end) begin
            phase_cnt    <= 8'd0;
            serial_clock <= 1'b1;
            state        <= S_HIGH;
`ifdef GPIO_LOADER_READBACK_EN
            rb_shift     <= {rb_shift[CFG_BITS-2:0], serial_return};
`endif
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        // End of high phase: next bit, next pad, or latch the chain.
        S_HIGH: begin
          if (phase_end) begin
            phase_cnt    <= 8'd0;
            serial_clock <= 1'b0;
            shreg        <= {shreg[CFG_BITS-2:0], 1'b0};
            if (bit_cnt != '0) begin
              bit_cnt     <= bit_cnt - BW'(1);
              serial_data <= shreg[CFG_BITS-2];
              state       <= S_LOW;
            end else if (cfg_idx != '0) begin
              cfg_idx   <= cfg_idx - IW'(1);
              fetch_cnt <= 1'b0;
              state     <= S_FETCH;
            end else begin
              serial_load <= 1'b1;
              serial_data <= 1'b0;
              state       <= S_LOAD;
            end
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        // Hold the latch strobe for one full phase.
        S_LOAD: begin
          if (phase_end) begin
            phase_cnt   <= 8'd0;
            serial_load <= 1'b0;
            state       <= S_FIN;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end

        S_FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          cfg_idx <= IDX_LAST;
          state   <= S_IDLE;
`ifdef GPIO_LOADER_READBACK_EN
          rb_word <= rb_shift;
`endif
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader. Two instances: a small chain (2 pads x 4 bits,
// CLK_DIV=2) and a full-size chain (38 pads x 13 bits, CLK_DIV=1). Each has a
// behavioural pad chain (per-pad shift words plus latched words) and a
// registered configuration store.
module tb_gpio_serial_loader;

  localparam int NA = 2;
  localparam int CA = 4;
  localparam int DA = 2;
  localparam int NB = 38;
  localparam int CB = 13;
  localparam int DB = 1;
  localparam int IA = $clog2(NA);
  localparam int IB = $clog2(NB);
  localparam int A_LAT = 1 + NA * (2 + 2 * DA * CA) + DA + 1;
  localparam int B_LAT = 1 + NB * (2 + 2 * DB * CB) + DB + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic          a_rst = 1'b1;
  logic          a_start = 1'b0;
  logic [IA-1:0] a_idx;
  logic [CA-1:0] a_cfg = '0;
  logic          a_sclk, a_sdat, a_sload, a_busy, a_done;
  logic [CA-1:0] a_store [NA];
`ifdef GPIO_LOADER_READBACK_EN
  logic          a_ret;
  logic [CA-1:0] a_rb;
`endif

  gpio_serial_loader #(.NPADS(NA), .CFG_BITS(CA), .CLK_DIV(DA)) u_dut_a (
    .wb_clk_i     (clk),
    .wb_rst_i     (a_rst),
    .start        (a_start),
    .cfg_idx      (a_idx),
    .cfg_data     (a_cfg),
    .serial_clock (a_sclk),
    .serial_data  (a_sdat),
    .serial_load  (a_sload),
    .busy         (a_busy),
`ifdef GPIO_LOADER_READBACK_EN
    .serial_return(a_ret),
    .rb_word      (a_rb),
`endif
    .done         (a_done)
  );

  // ---------------- instance B ----------------
  logic          b_rst = 1'b1;
  logic          b_start = 1'b0;
  logic [IB-1:0] b_idx;
  logic [CB-1:0] b_cfg = '0;
  logic          b_sclk, b_sdat, b_sload, b_busy, b_done;
  logic [CB-1:0] b_store [NB];
`ifdef GPIO_LOADER_READBACK_EN
  logic          b_ret;
  logic [CB-1:0] b_rb;
`endif

  gpio_serial_loader #(.NPADS(NB), .CFG_BITS(CB), .CLK_DIV(DB)) u_dut_b (
    .wb_clk_i     (clk),
    .wb_rst_i     (b_rst),
    .start        (b_start),
    .cfg_idx      (b_idx),
    .cfg_data     (b_cfg),
    .serial_clock (b_sclk),
    .serial_data  (b_sdat),
    .serial_load  (b_sload),
    .busy         (b_busy),
`ifdef GPIO_LOADER_READBACK_EN
    .serial_return(b_ret),
    .rb_word      (b_rb),
`endif
    .done         (b_done)
  );

  // ---------------- configuration stores (registered read) ----------------
  always @(posedge clk) a_cfg <= a_store[a_idx];
  always @(posedge clk) b_cfg <= (int'(b_idx) < NB) ? b_store[b_idx] : '0;

  // ---------------- chain models and monitors ----------------
  logic          a_sclk_q = 1'b0, a_sdat_q = 1'b0;
  int            a_edges = 0, a_load_cyc = 0, a_dones = 0, a_done_cyc = 0, a_viol = 0;
  logic          a_bits [$];
  logic [CA-1:0] a_sh  [NA] = '{default: '0};
  logic [CA-1:0] a_lat [NA] = '{default: '0};

  logic          b_sclk_q = 1'b0, b_sdat_q = 1'b0;
  int            b_edges = 0, b_load_cyc = 0, b_dones = 0, b_viol = 0;
  logic [CB-1:0] b_sh  [NB] = '{default: '0};
  logic [CB-1:0] b_lat [NB] = '{default: '0};

`ifdef GPIO_LOADER_READBACK_EN
  assign a_ret = a_sh[NA-1][CA-1];
  assign b_ret = b_sh[NB-1][CB-1];
`endif

  // Chain A: shift on serial_clock rise, latch while serial_load is high.
  always @(negedge clk) begin
    if (a_sclk && (a_sdat !== a_sdat_q)) a_viol++;
    if (a_sclk && !a_sclk_q) begin
      a_edges++;
      a_bits.push_back(a_sdat);
      for (int k = NA - 1; k > 0; k--) a_sh[k] = {a_sh[k][CA-2:0], a_sh[k-1][CA-1]};
      a_sh[0] = {a_sh[0][CA-2:0], a_sdat};
    end
    if (a_sload) begin
      a_load_cyc++;
      for (int k = 0; k < NA; k++) a_lat[k] = a_sh[k];
    end
    if (a_done) begin
      a_dones++;
      a_done_cyc = cyc;
    end
    a_sclk_q = a_sclk;
    a_sdat_q = a_sdat;
  end

  // Chain B: same pad behaviour at full size.
  always @(negedge clk) begin
    if (b_sclk && (b_sdat !== b_sdat_q)) b_viol++;
    if (b_sclk && !b_sclk_q) begin
      b_edges++;
      for (int k = NB - 1; k > 0; k--) b_sh[k] = {b_sh[k][CB-2:0], b_sh[k-1][CB-1]};
      b_sh[0] = {b_sh[0][CB-2:0], b_sdat};
    end
    if (b_sload) begin
      b_load_cyc++;
      for (int k = 0; k < NB; k++) b_lat[k] = b_sh[k];
    end
    if (b_done) b_dones++;
    b_sclk_q = b_sclk;
    b_sdat_q = b_sdat;
  end

  // ---------------- driver tasks ----------------
  task automatic a_clear();
    a_edges = 0; a_load_cyc = 0; a_dones = 0; a_viol = 0;
    a_bits.delete();
  endtask

  task automatic b_clear();
    b_edges = 0; b_load_cyc = 0; b_dones = 0; b_viol = 0;
  endtask

  task automatic a_pulse_start(output int t0);
    @(posedge clk); #1;
    a_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic b_pulse_start(output int t0);
    @(posedge clk); #1;
    b_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic a_wait_done(input int budget, input int n0, output bit ok);
    int k = 0;
    while (a_dones == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    ok = (a_dones != n0);
  endtask

  task automatic b_wait_done(input int budget, input int n0, output bit ok);
    int k = 0;
    while (b_dones == n0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    ok = (b_dones != n0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_sclk !== 1'b0)  begin errors++; $display("FAIL rst_sclk got %b exp 0", a_sclk); end
    checks++; if (a_sdat !== 1'b0)  begin errors++; $display("FAIL rst_sdat got %b exp 0", a_sdat); end
    checks++; if (a_sload !== 1'b0) begin errors++; $display("FAIL rst_sload got %b exp 0", a_sload); end
    checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", a_done); end
    checks++; if (int'(a_idx) != NA - 1) begin errors++; $display("FAIL rst_idx_a got %0d exp %0d", a_idx, NA - 1); end
    checks++; if (int'(b_idx) != NB - 1) begin errors++; $display("FAIL rst_idx_b got %0d exp %0d", b_idx, NB - 1); end
    checks++; if (b_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy_b got %b exp 0", b_busy); end
`ifdef GPIO_LOADER_READBACK_EN
    checks++; if (a_rb !== '0) begin errors++; $display("FAIL rst_rb got %h exp 0", a_rb); end
`endif
    a_rst = 1'b0; b_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_a();
    int  t0;
    bit  ok;
    logic exp_q [$];
    a_store[1] = 4'hA;
    a_store[0] = 4'h5;
    for (int p = NA - 1; p >= 0; p--)
      for (int b = CA - 1; b >= 0; b--) exp_q.push_back(a_store[p][b]);
    a_clear();
    a_pulse_start(t0);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", a_busy); end
    a_wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (a_edges != NA * CA) begin errors++; $display("FAIL basic_edges got %0d exp %0d", a_edges, NA * CA); end
    if (a_bits.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (a_bits[i] !== exp_q[i]) begin errors++; $display("FAIL basic_bit%0d got %b exp %b", i, a_bits[i], exp_q[i]); end
      end
    end
    checks++; if (a_done_cyc - t0 != A_LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", a_done_cyc - t0, A_LAT); end
    checks++; if (a_load_cyc != DA) begin errors++; $display("FAIL basic_load_cycles got %0d exp %0d", a_load_cyc, DA); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b exp 0", a_done); end
    checks++; if (a_viol != 0) begin errors++; $display("FAIL basic_data_stable got %0d exp 0", a_viol); end
    for (int k = 0; k < NA; k++) begin
      checks++;
      if (a_lat[k] !== a_store[k]) begin errors++; $display("FAIL basic_pad%0d got %h exp %h", k, a_lat[k], a_store[k]); end
    end
  endtask

  task automatic test_start_ignored();
    int t0;
    bit ok;
    for (int k = 0; k < NA; k++) a_store[k] = CA'($urandom_range(0, (1 << CA) - 1));
    a_clear();
    a_pulse_start(t0);
    repeat ($urandom_range(10, 30)) @(posedge clk);
    #1 a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_timeout got no done exp done"); end
    repeat (60) @(posedge clk);
    #1;
    checks++; if (a_edges != NA * CA) begin errors++; $display("FAIL ign_edges got %0d exp %0d", a_edges, NA * CA); end
    checks++; if (a_dones != 1) begin errors++; $display("FAIL ign_dones got %0d exp 1", a_dones); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b exp 0", a_busy); end
    for (int k = 0; k < NA; k++) begin
      checks++;
      if (a_lat[k] !== a_store[k]) begin errors++; $display("FAIL ign_pad%0d got %h exp %h", k, a_lat[k], a_store[k]); end
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    int k = 0;
    bit ok;
    logic [CA-1:0] old_lat [NA];
    for (int p = 0; p < NA; p++) old_lat[p] = a_lat[p];
    for (int p = 0; p < NA; p++) a_store[p] = ~old_lat[p];
    a_clear();
    a_pulse_start(t0);
    while ((a_edges < 4 || a_sclk) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (a_edges != 4) begin errors++; $display("FAIL mid_reach_bit5 got %0d exp 4", a_edges); end
    a_rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_sclk !== 1'b0)  begin errors++; $display("FAIL mid_sclk got %b exp 0", a_sclk); end
    checks++; if (a_sdat !== 1'b0)  begin errors++; $display("FAIL mid_sdat got %b exp 0", a_sdat); end
    checks++; if (a_sload !== 1'b0) begin errors++; $display("FAIL mid_sload got %b exp 0", a_sload); end
    checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL mid_busy got %b exp 0", a_busy); end
    checks++; if (a_done !== 1'b0)  begin errors++; $display("FAIL mid_done got %b exp 0", a_done); end
    checks++; if (int'(a_idx) != NA - 1) begin errors++; $display("FAIL mid_idx got %0d exp %0d", a_idx, NA - 1); end
    @(posedge clk); #1;
    a_rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (a_load_cyc != 0) begin errors++; $display("FAIL mid_no_load got %0d exp 0", a_load_cyc); end
    checks++; if (a_dones != 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", a_dones); end
    for (int p = 0; p < NA; p++) begin
      checks++;
      if (a_lat[p] !== old_lat[p]) begin errors++; $display("FAIL mid_keep_pad%0d got %h exp %h", p, a_lat[p], old_lat[p]); end
    end
    a_clear();
    a_pulse_start(t0);
    a_wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_rerun_timeout got no done exp done"); end
    for (int p = 0; p < NA; p++) begin
      checks++;
      if (a_lat[p] !== a_store[p]) begin errors++; $display("FAIL mid_rerun_pad%0d got %h exp %h", p, a_lat[p], a_store[p]); end
    end
  endtask

  task automatic test_chain_b();
    int t0;
    bit ok;
    for (int k = 0; k < NB; k++) b_store[k] = CB'($urandom_range(0, (1 << CB) - 1));
    b_clear();
    b_pulse_start(t0);
    b_wait_done(3000, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL chainb_timeout got no done exp done"); end
    checks++; if (b_edges != NB * CB) begin errors++; $display("FAIL chainb_edges got %0d exp %0d", b_edges, NB * CB); end
    checks++; if (b_load_cyc != DB) begin errors++; $display("FAIL chainb_load_cycles got %0d exp %0d", b_load_cyc, DB); end
    checks++; if (b_viol != 0) begin errors++; $display("FAIL chainb_data_stable got %0d exp 0", b_viol); end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (b_lat[k] !== b_store[k]) begin errors++; $display("FAIL chainb_pad%0d got %h exp %h", k, b_lat[k], b_store[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int k = 0;
    bit ok;
    logic [CB-1:0] w1 [NB];
    for (int p = 0; p < NB; p++) begin
      w1[p] = CB'($urandom_range(0, (1 << CB) - 1));
      b_store[p] = w1[p];
    end
    b_clear();
    b_pulse_start(t0);
    while (!b_done && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got %b exp 1", b_done); end
    checks++; if (cyc - t0 != B_LAT) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc - t0, B_LAT); end
    for (int p = 0; p < NB; p++) begin
      checks++;
      if (b_lat[p] !== w1[p]) begin errors++; $display("FAIL b2b_first_pad%0d got %h exp %h", p, b_lat[p], w1[p]); end
    end
    for (int p = 0; p < NB; p++) b_store[p] = CB'($urandom_range(0, (1 << CB) - 1));
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", b_busy); end
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b exp 0", b_done); end
    b_wait_done(3000, b_dones, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_second_timeout got no done exp done"); end
    checks++; if (b_edges != 2 * NB * CB) begin errors++; $display("FAIL b2b_edges got %0d exp %0d", b_edges, 2 * NB * CB); end
    checks++; if (b_dones != 2) begin errors++; $display("FAIL b2b_dones got %0d exp 2", b_dones); end
    checks++; if (b_viol != 0) begin errors++; $display("FAIL b2b_data_stable got %0d exp 0", b_viol); end
    for (int p = 0; p < NB; p++) begin
      checks++;
      if (b_lat[p] !== b_store[p]) begin errors++; $display("FAIL b2b_second_pad%0d got %h exp %h", p, b_lat[p], b_store[p]); end
    end
  endtask

`ifdef GPIO_LOADER_READBACK_EN
  task automatic test_readback();
    int t0;
    bit ok;
    a_sh[0] = 4'h3;
    a_sh[1] = 4'hC;
    a_store[1] = 4'hA;
    a_store[0] = 4'h5;
    a_clear();
    a_pulse_start(t0);
    a_wait_done(200, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rb_timeout got no done exp done"); end
    checks++; if (a_rb !== 4'h3) begin errors++; $display("FAIL rb_word got %h exp 3", a_rb); end
    checks++; if (a_lat[0] !== 4'h5) begin errors++; $display("FAIL rb_pad0 got %h exp 5", a_lat[0]); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < NA; k++) a_store[k] = '0;
    for (int k = 0; k < NB; k++) b_store[k] = '0;
    test_reset();
    test_basic_a();
    test_start_ignored();
    test_reset_mid();
    test_chain_b();
    test_back_to_back();
`ifdef GPIO_LOADER_READBACK_EN
    test_readback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

endmodule
